// File: rtl/ysyx_22041752_div_ctrl.sv
// Issue/retire controller for the iterative RV64M divider in EXE.
// Optional last-result cache: define YSYX_22041752_DIV_CACHE_EN.
`ifndef ysyx_22041752_RF_DATA_WD
`define ysyx_22041752_RF_DATA_WD 64
`endif

module ysyx_22041752_div_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        is_rem,
  input  logic        is_unsigned,
  input  logic        is_word,
  input  logic [`ysyx_22041752_RF_DATA_WD-1:0] src1,
  input  logic [`ysyx_22041752_RF_DATA_WD-1:0] src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [`ysyx_22041752_RF_DATA_WD-1:0] result,
  output logic [`ysyx_22041752_RF_DATA_WD-1:0] div_dividend,
  output logic [`ysyx_22041752_RF_DATA_WD-1:0] div_divisor,
  output logic        div_valid,
  output logic        div_signed,
  output logic        div_flush,
  input  logic        div_done,
  input  logic [`ysyx_22041752_RF_DATA_WD-1:0] div_quotient,
  input  logic [`ysyx_22041752_RF_DATA_WD-1:0] div_remainder
);

  localparam int DW = `ysyx_22041752_RF_DATA_WD;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic            sgn_q, sgn_d;
  logic            rem_q, rem_d;
  logic            word_q, word_d;
  logic [DW-1:0]   res_q, res_d;

  logic [DW-1:0]   a_fmt;
  logic [DW-1:0]   b_fmt;
  logic [DW-1:0]   sel;
  logic            ext;

  function automatic logic [DW-1:0] fmt_res(
    input logic [DW-1:0] v,
    input logic          w
  );
    return w ? {{(DW-32){v[31]}}, v[31:0]} : v;
  endfunction

  // W ops extend the low word; only signed ones replicate bit 31
  assign ext   = ~is_unsigned;
  assign a_fmt = is_word ? {{(DW-32){src1[31] & ext}}, src1[31:0]} : src1;
  assign b_fmt = is_word ? {{(DW-32){src2[31] & ext}}, src2[31:0]} : src2;
  assign sel   = rem_q ? div_remainder : div_quotient;

`ifdef YSYX_22041752_DIV_CACHE_EN
  logic            c_vld_q;
  logic [DW-1:0]   c_a_q;
  logic [DW-1:0]   c_b_q;
  logic            c_s_q;
  logic [DW-1:0]   c_quo_q;
  logic [DW-1:0]   c_rem_q;
  logic            c_hit;
  logic            c_wr;

  assign c_hit = c_vld_q && (c_a_q == a_fmt) &&
                 (c_b_q == b_fmt) && (c_s_q == ext);
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
    rem_d   = rem_q;
    word_d  = word_q;
    res_d   = res_q;
`ifdef YSYX_22041752_DIV_CACHE_EN
    c_wr    = 1'b0;
`endif
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_d     = a_fmt;
            b_d     = b_fmt;
            sgn_d   = ext;
            rem_d   = is_rem;
            word_d  = is_word;
            state_d = S_BUSY;
`ifdef YSYX_22041752_DIV_CACHE_EN
            if (c_hit) begin
              res_d   = fmt_res(is_rem ? c_rem_q : c_quo_q, is_word);
              state_d = S_DONE;
            end
`endif
          end
        end
        S_BUSY: begin
          if (div_done) begin
            res_d   = fmt_res(sel, word_q);
            state_d = S_DONE;
`ifdef YSYX_22041752_DIV_CACHE_EN
            c_wr    = 1'b1;
`endif
          end
        end
        S_DONE: begin
          if (out_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sgn_q   <= 1'b0;
      rem_q   <= 1'b0;
      word_q  <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sgn_q   <= sgn_d;
      rem_q   <= rem_d;
      word_q  <= word_d;
      res_q   <= res_d;
    end
  end

`ifdef YSYX_22041752_DIV_CACHE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      c_vld_q <= 1'b0;
      c_a_q   <= '0;
      c_b_q   <= '0;
      c_s_q   <= 1'b0;
      c_quo_q <= '0;
      c_rem_q <= '0;
    end else if (c_wr) begin
      c_vld_q <= 1'b1;
      c_a_q   <= a_q;
      c_b_q   <= b_q;
      c_s_q   <= sgn_q;
      c_quo_q <= div_quotient;
      c_rem_q <= div_remainder;
    end
  end
`endif

  assign in_ready     = (state_q == S_IDLE);
  assign out_valid    = (state_q == S_DONE);
  // Drop the request in the flush cycle so the divider sees the kill at once
  assign div_valid    = (state_q == S_BUSY) && !flush;
  assign div_flush    = flush;
  assign div_dividend = a_q;
  assign div_divisor  = b_q;
  assign div_signed   = sgn_q;
  assign result       = res_q;

endmodule

// File: tb/tb_ysyx_22041752_div_ctrl.sv
// Bench for ysyx_22041752_div_ctrl with a cycle-level divider stand-in
// and an ISA-level result model.
module tb_ysyx_22041752_div_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic        is_rem;
  logic        is_unsigned;
  logic        is_word;
  logic [63:0] src1;
  logic [63:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic [63:0] div_dividend;
  logic [63:0] div_divisor;
  logic        div_valid;
  logic        div_signed;
  logic        div_flush;
  logic        div_done;
  logic [63:0] div_quotient;
  logic [63:0] div_remainder;

  int tests = 0;
  int fails = 0;

  bit          cv = 1'b0;
  logic [63:0] ca, cb;
  bit          cs;

  always #5 clk = ~clk;

  ysyx_22041752_div_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .is_rem       (is_rem),
    .is_unsigned  (is_unsigned),
    .is_word      (is_word),
    .src1         (src1),
    .src2         (src2),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result),
    .div_dividend (div_dividend),
    .div_divisor  (div_divisor),
    .div_valid    (div_valid),
    .div_signed   (div_signed),
    .div_flush    (div_flush),
    .div_done     (div_done),
    .div_quotient (div_quotient),
    .div_remainder(div_remainder)
  );

  // Divider stand-in: counter restarts whenever div_valid drops
  logic [6:0]  dcnt;
  logic        dspec;
  logic [63:0] dq, dr;

  always @(posedge clk or posedge reset) begin
    if (reset) dcnt <= '0;
    else       dcnt <= div_valid ? dcnt + 7'd1 : 7'd0;
  end

  always_comb begin
    dspec = (div_divisor == 64'd0) ||
            (div_signed && div_dividend == 64'h8000_0000_0000_0000 &&
             div_divisor == 64'hFFFF_FFFF_FFFF_FFFF);
    dq = '1;
    dr = div_dividend;
    if (div_divisor != 64'd0) begin
      if (div_signed) begin
        if (dspec) begin
          dq = div_dividend;
          dr = 64'd0;
        end else begin
          dq = $signed(div_dividend) / $signed(div_divisor);
          dr = $signed(div_dividend) % $signed(div_divisor);
        end
      end else begin
        dq = div_dividend / div_divisor;
        dr = div_dividend % div_divisor;
      end
    end
  end

  assign div_done      = div_valid && (dspec ? dcnt == 7'd0 : dcnt == 7'd65);
  assign div_quotient  = div_done ? dq : ~dq;
  assign div_remainder = div_done ? dr : ~dr;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] fmt_op(input logic [63:0] v,
                                         input bit w, input bit u);
    if (!w) return v;
    if (u)  return {32'd0, v[31:0]};
    return {{32{v[31]}}, v[31:0]};
  endfunction

  // RISC-V M-extension result, computed at the instruction's own width
  function automatic logic [63:0] ref_res(input bit rem, input bit u,
                                          input bit w, input logic [63:0] a,
                                          input logic [63:0] b);
    logic [31:0] a32, b32, q32, r32, s32;
    logic [63:0] q64, r64;
    if (w) begin
      a32 = a[31:0];
      b32 = b[31:0];
      if (b32 == 0) begin
        q32 = '1; r32 = a32;
      end else if (u) begin
        q32 = a32 / b32; r32 = a32 % b32;
      end else if (a32 == 32'h8000_0000 && b32 == '1) begin
        q32 = a32; r32 = 0;
      end else begin
        q32 = $signed(a32) / $signed(b32);
        r32 = $signed(a32) % $signed(b32);
      end
      s32 = rem ? r32 : q32;
      return {{32{s32[31]}}, s32};
    end
    if (b == 0) begin
      q64 = '1; r64 = a;
    end else if (u) begin
      q64 = a / b; r64 = a % b;
    end else if (a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a; r64 = 0;
    end else begin
      q64 = $signed(a) / $signed(b);
      r64 = $signed(a) % $signed(b);
    end
    return rem ? r64 : q64;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input bit rem, input bit u, input bit w,
                        input logic [63:0] a, input logic [63:0] b,
                        input int hold, input string tag);
    logic [63:0] fa, fb, exp;
    bit          spec, hit, seen;
    int          lat, exp_lat;
    fa   = fmt_op(a, w, u);
    fb   = fmt_op(b, w, u);
    exp  = ref_res(rem, u, w, a, b);
    spec = (fb == 0) || (!u && fa == 64'h8000_0000_0000_0000 && fb == '1);
    exp_lat = spec ? 2 : 67;
    hit = 1'b0;
`ifdef YSYX_22041752_DIV_CACHE_EN
    if (cv && ca == fa && cb == fb && cs == !u) begin
      hit = 1'b1;
      exp_lat = 1;
    end
`endif
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    in_valid = 1'b1; is_rem = rem; is_unsigned = u; is_word = w;
    src1 = a; src2 = b;
    tick();
    in_valid = 1'b0;
    src1 = $urandom; src2 = $urandom;
    lat  = 1;
    seen = 1'b0;
    if (!hit) begin
      chk({tag, ".dividend"}, div_dividend, fa);
      chk({tag, ".divisor"}, div_divisor, fb);
      chk({tag, ".signed"}, 64'(div_signed), 64'(!u));
    end
    while (!out_valid && lat < 200) begin
      seen |= div_valid;
      tick();
      lat++;
    end
    chk({tag, ".latency"}, 64'(lat), 64'(exp_lat));
    chk({tag, ".result"}, result, exp);
    if (hit) chk({tag, ".no_div_valid"}, 64'(seen), 64'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, ".hold_valid"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_result"}, result, exp);
      chk({tag, ".hold_div_valid"}, 64'(div_valid), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, ".ready_after"}, 64'(in_ready), 64'd1);
    chk({tag, ".valid_after"}, 64'(out_valid), 64'd0);
    if (!hit && lat == exp_lat) begin
      cv = 1'b1; ca = fa; cb = fb; cs = !u;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] a, b;
    bit rem, u, w;
    int k;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    is_rem = 1'b0; is_unsigned = 1'b0; is_word = 1'b0;
    src1 = '0; src2 = '0;
    repeat (3) tick();
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.div_valid", 64'(div_valid), 64'd0);
    chk("rst.result", result, 64'd0);
    chk("rst.dividend", div_dividend, 64'd0);
    chk("rst.divisor", div_divisor, 64'd0);
    chk("rst.signed", 64'(div_signed), 64'd0);
    reset = 1'b0;
    tick();

    run_op(0, 0, 0, -64'sd7, 64'd2, 0, "div_m7_2");
    run_op(1, 1, 0, 64'd100, 64'd0, 0, "remu_by0");
    run_op(0, 0, 1, 64'h0000_0000_8000_0000, '1, 0, "divw_ovf");
    run_op(1, 1, 1, 64'h1234_5678_9ABC_DEF0, 64'd0, 0, "remuw_by0");
    run_op(0, 0, 1, 64'h55, 64'd0, 0, "divw_by0");
    run_op(1, 0, 0, 64'h8000_0000_0000_0000, '1, 1, "rem_ovf64");

    // flush in BUSY at T+30
    in_valid = 1'b1; is_rem = 1'b0; is_unsigned = 1'b0; is_word = 1'b0;
    src1 = 64'd1000; src2 = 64'd7;
    tick();
    in_valid = 1'b0;
    repeat (29) tick();
    chk("fl.busy_div_valid", 64'(div_valid), 64'd1);
    flush = 1'b1;
    #1;
    chk("fl.div_valid_drop", 64'(div_valid), 64'd0);
    chk("fl.div_flush", 64'(div_flush), 64'd1);
    tick();
    flush = 1'b0;
    chk("fl.idle", 64'(in_ready), 64'd1);
    k = 0;
    repeat (40) begin
      tick();
      k += int'(out_valid) + int'(div_valid);
    end
    chk("fl.quiet", 64'(k), 64'd0);
    run_op(0, 1, 0, 64'd10, 64'd3, 0, "divu_after_flush");

    // in_valid together with flush is dropped
    in_valid = 1'b1; flush = 1'b1; src1 = 64'd9; src2 = 64'd4;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    chk("flv.in_ready", 64'(in_ready), 64'd1);
    chk("flv.div_valid", 64'(div_valid), 64'd0);

    // back-pressure then same-operand REM
    run_op(0, 0, 0, 64'd17, 64'd5, 10, "div17_5_bp");
    run_op(1, 0, 0, 64'd17, 64'd5, 0, "rem17_5");

    // asynchronous reset mid-BUSY
    in_valid = 1'b1; is_rem = 1'b0; is_unsigned = 1'b1; is_word = 1'b0;
    src1 = 64'd77; src2 = 64'd6;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    #1;
    chk("arst.in_ready", 64'(in_ready), 64'd1);
    chk("arst.div_valid", 64'(div_valid), 64'd0);
    chk("arst.result", result, 64'd0);
    chk("arst.dividend", div_dividend, 64'd0);
    cv = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    for (int i = 0; i < 24; i++) begin
      rem = 1'($urandom);
      u   = 1'($urandom);
      w   = 1'($urandom);
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: b = 64'(b[4:0]);
        1: b = w ? {b[63:32], 32'd0} : 64'd0;
        2: begin
          a = w ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = '1;
        end
        3: b = {32'd0, b[31:0]};
        default: ;
      endcase
      run_op(rem, u, w, a, b, $urandom_range(0, 3), "rand");
      if ($urandom_range(0, 2) == 0)
        run_op(!rem, u, w, a, b, 0, "rand_pair");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
